// File: rtl/proc_fetch_queue_if.sv
// Fetch front-end bus: instruction-memory req/ack channel and the
// decode-side valid/ready channel carrying the queue head.
interface proc_fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              imem_err;

    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_incPC;
    logic              instr_ready;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data, imem_err,
        output instr_valid, instr, instr_pc, instr_incPC,
        input  instr_ready
    );

    // Memory + decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data, imem_err,
        input  instr_valid, instr, instr_pc, instr_incPC,
        output instr_ready
    );
endinterface

// File: rtl/proc_fetch_queue.sv
// Fetch front end: PC generator, single-outstanding req/ack instruction
// memory port and a DEPTH-entry prefetch queue feeding decode.
// A request is only issued when a queue slot is guaranteed for its data,
// so the queue cannot overflow. Redirects flush the queue; a request that
// is in flight during a redirect is drained and its data dropped.
module proc_fetch_queue #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_INC   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   halt,
    proc_fetch_queue_if.master     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic push, pop, credit, misaligned, head_valid;

    assign head_valid = (count_q != '0);
    // Redirect squashes both the acked data and the decode handshake.
    assign push       = (state_q == ST_REQ) && bus.imem_ack && !redirect;
    assign pop        = head_valid && bus.instr_ready && !redirect;
    assign misaligned = (redirect_pc % PC_STEP) != '0;

    // Next occupancy; redirect flushes regardless of push/pop.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A new request may issue only if its data will have a free slot.
    assign credit = (count_d < CNT_MAX);

    // Fetch control: request state and fetch PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!halt && credit) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    pc_d    = redirect ? redirect_pc : pc_q + PC_STEP;
                    state_d = (!halt && credit) ? ST_REQ : ST_IDLE;
                end else if (redirect) begin
                    // Request cannot be withdrawn: wait for its ack, then drop it.
                    pc_d    = redirect_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (bus.imem_ack) begin
                    state_d = (!halt && credit) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request address latches only when a new request starts, so it stays
    // stable through waits and drains.
    assign addr_d = (state_d == ST_REQ) ? pc_d : addr_q;

    // Sticky error: faulting fetch that is kept, or misaligned redirect target.
    assign err_d = err_q | (push && bus.imem_err) | (redirect && misaligned);

    // Control state, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_RST;
            addr_q   <= PC_RST;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Queue storage written on push.
    // NOTE: storage has no reset; occupancy gates every read, so stale
    // contents are never visible and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_data;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

    assign bus.imem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign bus.imem_addr   = addr_q;

    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? data_mem[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr_q] : '0;
    assign bus.instr_incPC = head_valid ? pc_mem[rd_ptr_q] + PC_STEP : '0;

    assign count = count_q;
    assign err   = err_q;
endmodule

// File: tb/tb_proc_fetch_queue.sv
// Self-checking bench for proc_fetch_queue: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_proc_fetch_queue;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [2:0]  count;
    logic        err;

    proc_fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    proc_fetch_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0), .PC_INC(2)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .bus(bus), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model configuration and observation counters.
    int          mem_lat    = 0;
    bit          rand_lat   = 0;
    bit          err_en     = 0;
    logic [15:0] err_addr   = 16'h0;
    int          ack_total  = 0;
    int          req_starts = 0;
    int          addr_moved = 0;
    int          halt_viol  = 0;
    int          occ_bad    = 0;

    typedef struct {
        bit          is_redir;
        logic [15:0] pc;
        logic [15:0] data;
        logic [15:0] inc;
    } ev_t;
    ev_t ev_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Instruction memory with configurable latency; also logs decode-side
    // events and protocol observations. Runs on the falling edge.
    initial begin : bench_mem
        int          cnt;
        int          cur_lat;
        logic        prev_req;
        logic        prev_halt;
        logic [15:0] prev_addr;
        cnt = 0; cur_lat = 0; prev_req = 0; prev_halt = 0; prev_addr = 0;
        bus.imem_ack = 1'b0; bus.imem_data = 16'hDEAD; bus.imem_err = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0; prev_halt = 0; cnt = 0; cur_lat = mem_lat;
                bus.imem_ack = 1'b0; bus.imem_err = 1'b1;
            end else begin
                if (bus.imem_req && prev_req && !bus.imem_ack && bus.imem_addr !== prev_addr)
                    addr_moved++;
                if (bus.imem_req && (!prev_req || bus.imem_ack)) begin
                    req_starts++;
                    if (prev_halt) halt_viol++;
                end
                if (count > DEPTH || bus.instr_valid !== (count != 0)) occ_bad++;
                if (redirect)
                    ev_q.push_back('{is_redir: 1'b1, pc: redirect_pc, data: 16'h0, inc: 16'h0});
                else if (bus.instr_valid && bus.instr_ready)
                    ev_q.push_back('{is_redir: 1'b0, pc: bus.instr_pc, data: bus.instr, inc: bus.instr_incPC});
                prev_req = bus.imem_req; prev_addr = bus.imem_addr; prev_halt = halt;

                if (!bus.imem_req) begin
                    bus.imem_ack = 1'b0; bus.imem_data = 16'hDEAD; bus.imem_err = 1'b1; cnt = 0;
                end else if (cnt >= cur_lat) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem_word(bus.imem_addr);
                    bus.imem_err  = err_en && (bus.imem_addr == err_addr);
                    ack_total++;
                    cnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end else begin
                    bus.imem_ack = 1'b0; bus.imem_data = 16'hDEAD; bus.imem_err = 1'b1; cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic rdy, input logic hlt);
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = hlt;
        bus.instr_ready = rdy; mem_lat = lat; rand_lat = 0; err_en = 0;
        repeat (2) tick();
        ev_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0; bus.instr_ready = 1'b1;
        repeat (3) tick();
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr: got %h want 0000", bus.imem_addr); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        checks++; if ({bus.instr, bus.instr_pc, bus.instr_incPC} !== 48'h0) begin failures++;
            $display("FAIL reset_head: got %h/%h/%h want 0", bus.instr, bus.instr_pc, bus.instr_incPC); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_pc;
        do_reset(0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin failures++;
            $display("FAIL zw_first_req: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_pc = 16'(2 * k);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)
                || bus.instr_incPC !== exp_pc + 16'd2) begin
                failures++;
                $display("FAIL zw_stream%0d: got v=%b pc=%h d=%h inc=%h want v=1 pc=%h d=%h inc=%h", k,
                         bus.instr_valid, bus.instr_pc, bus.instr, bus.instr_incPC,
                         exp_pc, mem_word(exp_pc), exp_pc + 16'd2);
            end
        end
    endtask

    task automatic test_full_queue();
        int a0;
        do_reset(0, 1'b0, 1'b0);
        a0 = ack_total;
        repeat (10) tick();
        checks++; if (ack_total - a0 != 4) begin failures++; $display("FAIL full_acks: got %0d want 4", ack_total - a0); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL full_req_idle: got %b want 0", bus.imem_req); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (count !== 3'd3 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0008 || bus.instr_pc !== 16'h0002) begin
            failures++;
            $display("FAIL full_refill_req: got cnt=%0d req=%b addr=%h head=%h want cnt=3 req=1 addr=0008 head=0002",
                     count, bus.imem_req, bus.imem_addr, bus.instr_pc);
        end
        repeat (6) tick();
        checks++; if (ack_total - a0 != 5 || count !== 3'd4 || bus.imem_req !== 1'b0) begin failures++;
            $display("FAIL full_one_refill: got acks=%0d cnt=%0d req=%b want acks=5 cnt=4 req=0",
                     ack_total - a0, count, bus.imem_req); end
    endtask

    task automatic test_drain();
        bit found;
        bit stale;
        do_reset(3, 1'b1, 1'b0);
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        checks++; if (count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++;
            $display("FAIL drain_flush: got cnt=%0d v=%b want cnt=0 v=0", count, bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failures++;
            $display("FAIL drain_hold: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failures++;
            $display("FAIL drain_hold2: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin failures++;
            $display("FAIL drain_next_req: got req=%b addr=%h want req=1 addr=0040", bus.imem_req, bus.imem_addr); end
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            if (bus.instr_valid === 1'b1) found = 1;
        end
        checks++; if (!found || bus.instr_pc !== 16'h0040 || bus.instr !== mem_word(16'h0040)) begin failures++;
            $display("FAIL drain_first_instr: got found=%0d pc=%h d=%h want pc=0040 d=%h",
                     found, bus.instr_pc, bus.instr, mem_word(16'h0040)); end
        stale = 0;
        foreach (ev_q[i]) if (!ev_q[i].is_redir && ev_q[i].pc == 16'h0000) stale = 1;
        checks++; if (stale) begin failures++; $display("FAIL drain_discard: got stale pc 0000 delivered want none"); end
    endtask

    task automatic test_redirect_pop();
        bit found;
        do_reset(0, 1'b0, 1'b0);
        repeat (3) tick();
        halt = 1'b1;
        tick();
        checks++; if (count !== 3'd3 || bus.imem_req !== 1'b0) begin failures++;
            $display("FAIL rp_setup: got cnt=%0d req=%b want cnt=3 req=0", count, bus.imem_req); end
        bus.instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        checks++; if (count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++;
            $display("FAIL rp_flush: got cnt=%0d v=%b want cnt=0 v=0", count, bus.instr_valid); end
        tick();
        checks++; if (count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++;
            $display("FAIL rp_no_dup: got cnt=%0d v=%b want cnt=0 v=0", count, bus.instr_valid); end
        halt = 1'b0;
        found = 0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (bus.instr_valid === 1'b1) found = 1;
        end
        checks++; if (!found || bus.instr_pc !== 16'h0100) begin failures++;
            $display("FAIL rp_target: got found=%0d pc=%h want pc=0100", found, bus.instr_pc); end
    endtask

    task automatic test_halt();
        int  s0;
        bit  seen;
        do_reset(2, 1'b1, 1'b0);
        tick();
        tick();
        s0 = req_starts;
        halt = 1'b1;
        repeat (8) tick();
        checks++; if (req_starts != s0 || bus.imem_req !== 1'b0) begin failures++;
            $display("FAIL halt_block: got new_reqs=%0d req=%b want 0 and 0", req_starts - s0, bus.imem_req); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL halt_drain: got cnt=%0d want 0", count); end
        seen = 0;
        foreach (ev_q[i]) if (!ev_q[i].is_redir && ev_q[i].pc == 16'h0000 && ev_q[i].data == mem_word(16'h0)) seen = 1;
        checks++; if (!seen) begin failures++; $display("FAIL halt_outstanding_pushed: got missing pc 0000 want delivered"); end
        halt = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin failures++;
            $display("FAIL halt_resume: got req=%b addr=%h want req=1 addr=0002", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_err();
        int first;
        bit seen;
        do_reset(0, 1'b1, 1'b0);
        err_en = 1; err_addr = 16'h0010;
        first = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (err === 1'b1 && first == 0) first = t;
        end
        checks++; if (first != 10) begin failures++; $display("FAIL err_set_cycle: got %0d want 10", first); end
        err_en = 0;
        repeat (5) tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
        seen = 0;
        foreach (ev_q[i]) if (!ev_q[i].is_redir && ev_q[i].pc == 16'h0010 && ev_q[i].data == mem_word(16'h0010)) seen = 1;
        checks++; if (!seen) begin failures++; $display("FAIL err_entry_pushed: got missing pc 0010 want delivered"); end
        do_reset(0, 1'b1, 1'b1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_rst_clear: got %b want 0", err); end
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_aligned_redir: got %b want 0", err); end
        redirect_pc = 16'h0013;
        tick();
        redirect = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_misaligned: got %b want 1", err); end
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_misaligned_sticky: got %b want 1", err); end
    endtask

    task automatic test_async_reset();
        do_reset(0, 1'b1, 1'b0);
        mem_lat = 6;
        repeat (3) tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin failures++;
            $display("FAIL arst_setup: got req=%b addr=%h want req=1 addr=0002", bus.imem_req, bus.imem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000 || count !== 3'd0) begin failures++;
            $display("FAIL arst_immediate: got req=%b addr=%h cnt=%0d want req=0 addr=0000 cnt=0",
                     bus.imem_req, bus.imem_addr, count); end
    endtask

    // Reference model: the delivered stream must be consecutive PCs from
    // the last redirect target (or reset PC), each carrying memory contents.
    task automatic test_random();
        logic [15:0] exp_pc;
        int          pops;
        do_reset(0, 1'b1, 1'b0);
        rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            halt            = ($urandom_range(0, 9) < 2);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_pc     = 16'($urandom) & 16'hFFFE;
            tick();
        end
        redirect = 1'b0; halt = 1'b0; bus.instr_ready = 1'b1;
        repeat (20) tick();
        exp_pc = 16'h0000;
        pops   = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].is_redir) begin
                exp_pc = ev_q[i].pc;
            end else begin
                pops++;
                checks++;
                if (ev_q[i].pc !== exp_pc || ev_q[i].data !== mem_word(exp_pc) || ev_q[i].inc !== exp_pc + 16'd2) begin
                    failures++;
                    $display("FAIL rand_stream: got pc=%h d=%h inc=%h want pc=%h d=%h inc=%h",
                             ev_q[i].pc, ev_q[i].data, ev_q[i].inc, exp_pc, mem_word(exp_pc), exp_pc + 16'd2);
                    exp_pc = ev_q[i].pc;
                end
                exp_pc = exp_pc + 16'd2;
            end
        end
        checks++; if (pops < 100) begin failures++; $display("FAIL rand_progress: got %0d pops want >=100", pops); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rand_err: got %b want 0", err); end
        checks++; if (addr_moved != 0) begin failures++; $display("FAIL addr_stable: got %0d changes want 0", addr_moved); end
        checks++; if (halt_viol != 0) begin failures++; $display("FAIL halt_no_new_req: got %0d want 0", halt_viol); end
        checks++; if (occ_bad != 0) begin failures++; $display("FAIL occupancy_valid: got %0d bad cycles want 0", occ_bad); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_full_queue();
        test_drain();
        test_redirect_pop();
        test_halt();
        test_err();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
